// File: rtl/sort_ctrl_oet.sv
// sort_ctrl_oet: sequencing controller for an odd-even transposition sorter.
// A frame of NUM_DATA words is loaded over a valid/ready stream. Compare-exchange
// phases then run over an internal buffer, one phase per clock. The sorted frame
// is streamed out with o_last marking the final word.
// Optional build macro: SORT_EARLY_EXIT_EN. When it is defined, SORT stops once
// two consecutive phases (index >= 1) perform no exchange. Output data is the same
// in both builds.

// compare_block: compare-exchange cell. Mode 0 routes min to o_less_data;
// mode 1 routes max to o_less_data, so the "lo" slot receives the larger word.
module compare_block #(
  parameter int SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic                 i_mode,
  output logic [SIZE_DATA-1:0] o_less_data,
  output logic [SIZE_DATA-1:0] o_greater_data
);

  logic a_gt_b_s;

  // Strict unsigned compare; equal words pass straight through.
  always_comb begin
    a_gt_b_s = (i_data_a > i_data_b);
    if (a_gt_b_s ^ i_mode) begin
      o_less_data    = i_data_b;
      o_greater_data = i_data_a;
    end else begin
      o_less_data    = i_data_a;
      o_greater_data = i_data_b;
    end
  end

endmodule

module sort_ctrl_oet #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_DATA  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_busy
);

  localparam int CW = (NUM_DATA > 2) ? $clog2(NUM_DATA) : 1;
  localparam int NP = NUM_DATA / 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DATA - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [CW-1:0]        wr_cnt_r;
  logic [CW-1:0]        rd_cnt_r;
  logic [CW-1:0]        phase_cnt_r;
  logic                 mode_r;
  logic [SIZE_DATA-1:0] data_buf_r [NUM_DATA];

  logic                 accept_s;
  logic                 emit_s;
  logic                 odd_phase_s;
  logic                 sort_done_s;
  logic [SIZE_DATA-1:0] cmp_a_s       [NP];
  logic [SIZE_DATA-1:0] cmp_b_s       [NP];
  logic [SIZE_DATA-1:0] cmp_less_s    [NP];
  logic [SIZE_DATA-1:0] cmp_greater_s [NP];

  assign accept_s    = (state_r == ST_LOAD) && i_valid;
  assign emit_s      = (state_r == ST_DRAIN) && i_ready;
  assign odd_phase_s = phase_cnt_r[0];

  // Compare cells. In odd phases the top cell has no pair and its result is ignored.
  for (genvar k = 0; k < NP; k++) begin : g_cell
    if (k == NP - 1) begin : g_edge
      assign cmp_a_s[k] = data_buf_r[2*k];
      assign cmp_b_s[k] = data_buf_r[2*k+1];
    end else begin : g_inner
      assign cmp_a_s[k] = odd_phase_s ? data_buf_r[2*k+1] : data_buf_r[2*k];
      assign cmp_b_s[k] = odd_phase_s ? data_buf_r[2*k+2] : data_buf_r[2*k+1];
    end
    compare_block #(.SIZE_DATA(SIZE_DATA)) u_cmp (
      .i_data_a       (cmp_a_s[k]),
      .i_data_b       (cmp_b_s[k]),
      .i_mode         (mode_r),
      .o_less_data    (cmp_less_s[k]),
      .o_greater_data (cmp_greater_s[k])
    );
  end

`ifdef SORT_EARLY_EXIT_EN
  logic swap_any_s;
  logic prev_swap_r;

  // Detect whether any active pair exchanged in the current phase.
  always_comb begin
    swap_any_s = 1'b0;
    for (int k = 0; k < NP; k++) begin
      swap_any_s = swap_any_s |
                   ((cmp_less_s[k] != cmp_a_s[k]) && ((k < NP - 1) || !odd_phase_s));
    end
  end

  // Remember the previous phase's exchange flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_swap_r <= 1'b0;
    end else if (state_r == ST_SORT) begin
      prev_swap_r <= swap_any_s;
    end
  end

  assign sort_done_s = (phase_cnt_r == LAST_IDX) ||
                       ((phase_cnt_r != CNT_ZERO) && !swap_any_s && !prev_swap_r);
`else
  assign sort_done_s = (phase_cnt_r == LAST_IDX);
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: LOAD -> SORT -> DRAIN -> LOAD.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (accept_s && (wr_cnt_r == LAST_IDX)) begin
          state_next_s = ST_SORT;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_SORT: begin
        if (sort_done_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_SORT;
        end
      end
      ST_DRAIN: begin
        if (emit_s && (rd_cnt_r == LAST_IDX)) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_LOAD;
    endcase
  end

  // Write, phase and read counters plus the per-frame mode latch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt_r    <= CNT_ZERO;
      rd_cnt_r    <= CNT_ZERO;
      phase_cnt_r <= CNT_ZERO;
      mode_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_cnt_r <= (wr_cnt_r == LAST_IDX) ? CNT_ZERO : (wr_cnt_r + CNT_ONE);
        if (wr_cnt_r == CNT_ZERO) begin
          mode_r <= i_mode;
        end
      end
      if (state_r == ST_SORT) begin
        phase_cnt_r <= sort_done_s ? CNT_ZERO : (phase_cnt_r + CNT_ONE);
      end
      if (emit_s) begin
        rd_cnt_r <= (rd_cnt_r == LAST_IDX) ? CNT_ZERO : (rd_cnt_r + CNT_ONE);
      end
    end
  end

  // Frame buffer: loaded word by word, then rewritten by the compare cells.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_DATA; i++) begin
        data_buf_r[i] <= '0;
      end
    end else if (accept_s) begin
      data_buf_r[wr_cnt_r] <= i_data;
    end else if (state_r == ST_SORT) begin
      if (!odd_phase_s) begin
        for (int k = 0; k < NP; k++) begin
          data_buf_r[2*k]   <= cmp_less_s[k];
          data_buf_r[2*k+1] <= cmp_greater_s[k];
        end
      end else begin
        for (int k = 0; k < NP - 1; k++) begin
          data_buf_r[2*k+1] <= cmp_less_s[k];
          data_buf_r[2*k+2] <= cmp_greater_s[k];
        end
      end
    end
  end

  // Output decode. Only registered state is used, so there is no input-to-output path.
  always_comb begin
    o_ready = (state_r == ST_LOAD);
    o_valid = (state_r == ST_DRAIN);
    o_busy  = (state_r == ST_SORT) || (state_r == ST_DRAIN);
    if (state_r == ST_DRAIN) begin
      o_data = data_buf_r[rd_cnt_r];
      o_last = (rd_cnt_r == LAST_IDX);
    end else begin
      o_data = '0;
      o_last = 1'b0;
    end
  end

endmodule
